// File: rtl/psum_pad_if.sv
// PE-side bus of the partial-sum scratchpad: psum read/write port, drain control
// and the rdy/ack drain stream toward the PE output network.
interface psum_pad_if #(
    parameter int DEPTH = 32,
    parameter int DW    = 32
);
    localparam int ADDRWD = $clog2(DEPTH) + 1;

    logic              i_clear;
    logic              i_psum_mode;
    logic              i_read;
    logic [ADDRWD-1:0] i_raddr;
    logic              i_write;
    logic [ADDRWD-1:0] i_waddr;
    logic [DW-1:0]     i_wdata;
    logic [DW-1:0]     o_rdata;
    logic              o_rvalid;
    logic              i_drain_start;
    logic [ADDRWD-1:0] i_drain_size;
    logic              o_Psum_rdy;
    logic              i_Psum_ack;
    logic [DW-1:0]     o_Psum_data;
    logic              o_busy;
    logic              o_drain_done;
    logic              o_err;

    modport slave (
        input  i_clear, i_psum_mode, i_read, i_raddr, i_write, i_waddr, i_wdata,
               i_drain_start, i_drain_size, i_Psum_ack,
        output o_rdata, o_rvalid, o_Psum_rdy, o_Psum_data, o_busy, o_drain_done, o_err
    );

    modport master (
        output i_clear, i_psum_mode, i_read, i_raddr, i_write, i_waddr, i_wdata,
               i_drain_start, i_drain_size, i_Psum_ack,
        input  o_rdata, o_rvalid, o_Psum_rdy, o_Psum_data, o_busy, o_drain_done, o_err
    );
endinterface

// File: rtl/psum_pad.sv
// Partial-sum scratchpad: D16/D32 packed psum storage with a 1-cycle read port
// and a bubble-free rdy/ack drain stream toward the PE output network.
module psum_pad #(
    parameter int DEPTH = 32,
    parameter int DW    = 32
) (
    input logic       i_clk,
    input logic       i_rst_n,
    psum_pad_if.slave bus
);
    localparam int EW     = $clog2(DEPTH);
    localparam int ADDRWD = EW + 1;
    localparam int HW     = DW / 2;
    localparam logic [ADDRWD-1:0] DEPTH_SZ = ADDRWD'(DEPTH);

    typedef enum logic {IDLE, DRAIN} state_t;
    state_t state_q, state_d;

    logic [DW-1:0]     mem_q [DEPTH];
    logic [DW-1:0]     rdata_q, rdata_d, pdata_q, pdata_d;
    logic              rvalid_q, rvalid_d, done_q, done_d, err_q, err_d;
    logic [EW-1:0]     ptr_q, ptr_d;
    logic [ADDRWD-1:0] size_q, size_d, size_sat;

    logic              busy, wr_en, rd_en, start_go, ack_fire, last_beat, collide;
    logic [EW-1:0]     wr_entry, rd_entry, load_idx;
    logic              wr_half, rd_half;
    logic [DW-1:0]     wr_word, rd_stored, rd_word, load_word;
    logic [HW-1:0]     rd_half_val;

    assign busy      = (state_q == DRAIN);
    assign wr_en     = bus.i_write && !busy;
    assign rd_en     = bus.i_read && !busy;
    assign start_go  = !busy && bus.i_drain_start && !bus.i_clear;
    assign ack_fire  = busy && bus.i_Psum_ack && !bus.i_clear;
    assign last_beat = (({1'b0, ptr_q} + ADDRWD'(1)) == size_q);
    assign size_sat  = (bus.i_drain_size == '0 || bus.i_drain_size > DEPTH_SZ)
                       ? DEPTH_SZ : bus.i_drain_size;

    always_comb begin
        if (bus.i_psum_mode) begin
            wr_entry = bus.i_waddr[ADDRWD-1:1];
            wr_half  = bus.i_waddr[0];
            rd_entry = bus.i_raddr[ADDRWD-1:1];
            rd_half  = bus.i_raddr[0];
        end else begin
            wr_entry = bus.i_waddr[EW-1:0];
            wr_half  = 1'b0;
            rd_entry = bus.i_raddr[EW-1:0];
            rd_half  = 1'b0;
        end
    end

    // D16 writes merge into the stored word so the other half survives.
    always_comb begin
        wr_word = bus.i_wdata;
        if (bus.i_psum_mode) begin
            wr_word = mem_q[wr_entry];
            if (wr_half) wr_word[DW-1:HW] = bus.i_wdata[HW-1:0];
            else         wr_word[HW-1:0]  = bus.i_wdata[HW-1:0];
        end
    end

    always_comb begin
        rd_stored   = mem_q[rd_entry];
        rd_half_val = rd_half ? rd_stored[DW-1:HW] : rd_stored[HW-1:0];
        collide     = wr_en && (wr_entry == rd_entry) && (wr_half == rd_half);
        if (bus.i_psum_mode) begin
            if (collide) rd_half_val = bus.i_wdata[HW-1:0];
            rd_word = {{HW{rd_half_val[HW-1]}}, rd_half_val};
        end else begin
            rd_word = collide ? bus.i_wdata : rd_stored;
        end
    end

    // A write landing on the entry being loaded for drain is forwarded so the beat sees it.
    always_comb begin
        load_idx  = start_go ? '0 : ptr_q + EW'(1);
        load_word = (wr_en && wr_entry == load_idx) ? wr_word : mem_q[load_idx];
    end

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        pdata_d  = pdata_q;
        ptr_d    = ptr_q;
        size_d   = size_q;
        done_d   = 1'b0;
        err_d    = err_q;
        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
        end
        if (bus.i_clear) begin
            err_d = 1'b0;
        end else if (busy && (bus.i_read || bus.i_write || bus.i_drain_start)) begin
            err_d = 1'b1;
        end
        if (start_go) begin
            size_d  = size_sat;
            ptr_d   = '0;
            pdata_d = load_word;
        end else if (ack_fire && !last_beat) begin
            ptr_d   = ptr_q + EW'(1);
            pdata_d = load_word;
        end
        if (ack_fire && last_beat) done_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem_q[wr_entry] <= wr_word;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            pdata_q  <= '0;
            ptr_q    <= '0;
            size_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            pdata_q  <= pdata_d;
            ptr_q    <= ptr_d;
            size_q   <= size_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_go) state_d = DRAIN;
            DRAIN:   if (bus.i_clear || (ack_fire && last_beat)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy     = (state_q == DRAIN);
        bus.o_Psum_rdy = (state_q == DRAIN);
    end

    assign bus.o_rdata      = rdata_q;
    assign bus.o_rvalid     = rvalid_q;
    assign bus.o_Psum_data  = pdata_q;
    assign bus.o_drain_done = done_q;
    assign bus.o_err        = err_q;
endmodule

// File: tb/tb_psum_pad.sv
// Self-checking bench for psum_pad: a word-array model with write-then-read semantics
// is compared every cycle, plus directed literal checks on key values.
module tb_psum_pad;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    psum_pad_if #(.DEPTH(32), .DW(32)) bus ();

    psum_pad #(.DEPTH(32), .DW(32)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] m_mem [32];
    bit          m_busy;
    bit          was_busy;
    int          m_idx;
    int          m_n;
    logic [31:0] exp_rdata;
    bit          exp_rvalid;
    bit          exp_done;
    bit          exp_err;
    logic [31:0] exp_beats [$];

    function automatic int entry_of(bit mode, int addr);
        return mode ? ((addr >> 1) & 31) : (addr & 31);
    endfunction

    task automatic model_write(bit mode, int addr, logic [31:0] d);
        int e = entry_of(mode, addr);
        if (!mode)           m_mem[e] = d;
        else if (addr & 1)   m_mem[e][31:16] = d[15:0];
        else                 m_mem[e][15:0]  = d[15:0];
    endtask

    function automatic logic [31:0] model_read(bit mode, int addr);
        logic [31:0] w = m_mem[entry_of(mode, addr)];
        logic [15:0] h;
        if (!mode) return w;
        h = (addr & 1) ? w[31:16] : w[15:0];
        return {{16{h[15]}}, h};
    endfunction

    // Write is applied before the read, which yields forwarding on a same-location collision.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_idx = 0; m_n = 0;
            exp_rdata = 0; exp_rvalid = 0; exp_done = 0; exp_err = 0;
        end else begin
            was_busy   = m_busy;
            exp_rvalid = 0;
            exp_done   = 0;
            if (!was_busy && bus.i_write)
                model_write(bus.i_psum_mode, int'(bus.i_waddr), bus.i_wdata);
            if (!was_busy && bus.i_read) begin
                exp_rvalid = 1;
                exp_rdata  = model_read(bus.i_psum_mode, int'(bus.i_raddr));
            end
            if (bus.i_clear) exp_err = 0;
            else if (was_busy && (bus.i_read || bus.i_write || bus.i_drain_start)) exp_err = 1;
            if (bus.i_clear) begin
                m_busy = 0;
            end else if (!was_busy && bus.i_drain_start) begin
                m_busy = 1;
                m_idx  = 0;
                m_n    = (bus.i_drain_size == 0 || bus.i_drain_size > 32) ? 32 : int'(bus.i_drain_size);
            end else if (was_busy && bus.i_Psum_ack) begin
                if (m_idx == m_n - 1) begin
                    m_busy   = 0;
                    exp_done = 1;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        checkOutput("rvalid", 32'(bus.o_rvalid), 32'(exp_rvalid));
        checkOutput("rdata", bus.o_rdata, exp_rdata);
        checkOutput("psum_rdy", 32'(bus.o_Psum_rdy), 32'(m_busy));
        checkOutput("busy", 32'(bus.o_busy), 32'(m_busy));
        checkOutput("drain_done", 32'(bus.o_drain_done), 32'(exp_done));
        checkOutput("err", 32'(bus.o_err), 32'(exp_err));
        if (m_busy) checkOutput("psum_data", bus.o_Psum_data, m_mem[m_idx]);
    end

    task automatic applyStimulus(bit mode, bit wr, int waddr, logic [31:0] wdata, bit rd, int raddr);
        @(negedge clk);
        bus.i_psum_mode = mode;
        bus.i_write     = wr;
        bus.i_waddr     = 6'(waddr);
        bus.i_wdata     = wdata;
        bus.i_read      = rd;
        bus.i_raddr     = 6'(raddr);
        @(posedge clk);
        #1;
        bus.i_write = 0;
        bus.i_read  = 0;
    endtask

    task automatic do_write(bit mode, int addr, logic [31:0] d);
        applyStimulus(mode, 1, addr, d, 0, 0);
    endtask

    task automatic do_read(string name, bit mode, int addr, logic [31:0] exp);
        applyStimulus(mode, 0, 0, 0, 1, addr);
        checkOutput({name, "_rvalid"}, 32'(bus.o_rvalid), 32'd1);
        checkOutput(name, bus.o_rdata, exp);
    endtask

    task automatic start_drain(int size);
        @(negedge clk);
        bus.i_Psum_ack    = 0;
        bus.i_drain_start = 1;
        bus.i_drain_size  = 6'(size);
        @(posedge clk);
        #1;
        bus.i_drain_start = 0;
    endtask

    task automatic drain_consume(int n, bit toggle);
        int got = 0;
        int cyc = 0;
        logic [31:0] seen;
        bit rdy_s;
        while (got < n && cyc < 100) begin
            @(negedge clk);
            rdy_s = bus.o_Psum_rdy;
            seen  = bus.o_Psum_data;
            bus.i_Psum_ack = (toggle && (cyc % 2 == 0)) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (rdy_s && bus.i_Psum_ack) begin
                checkOutput($sformatf("beat%0d", got), seen, exp_beats[got]);
                got++;
            end
            cyc++;
        end
        checkOutput("drain_beats", 32'(got), 32'(n));
    endtask

    task automatic check_drain_end();
        checkOutput("done_pulse", 32'(bus.o_drain_done), 32'd1);
        checkOutput("rdy_after", 32'(bus.o_Psum_rdy), 32'd0);
        checkOutput("busy_after", 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        bus.i_Psum_ack = 0;
        @(posedge clk);
        #1;
        checkOutput("done_once", 32'(bus.o_drain_done), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk = 0;
        rst_n = 0;
        bus.i_clear = 0; bus.i_psum_mode = 0; bus.i_read = 0; bus.i_raddr = 0;
        bus.i_write = 0; bus.i_waddr = 0; bus.i_wdata = 0; bus.i_drain_start = 0;
        bus.i_drain_size = 0; bus.i_Psum_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rdy", 32'(bus.o_Psum_rdy), 32'd0);
        checkOutput("reset_rdata", bus.o_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 32; i++) do_write(0, i, 32'h1000_0000 + 32'(i));
        do_write(0, 0, 32'h11);
        do_write(0, 1, 32'h22);
        do_write(0, 2, 32'h33);
        do_write(0, 3, 32'h44);
        do_read("d32_read2", 0, 2, 32'h33);

        do_write(1, 5, 32'h8001);
        do_write(1, 4, 32'h0007);
        do_read("d16_read5", 1, 5, 32'hFFFF_8001);
        do_read("d16_read4", 1, 4, 32'h0000_0007);
        do_read("d32_entry2", 0, 2, 32'h8001_0007);

        exp_beats = '{32'h11, 32'h22, 32'h8001_0007};
        start_drain(3);
        drain_consume(3, 0);
        check_drain_end();

        applyStimulus(0, 1, 3, 32'hABCD, 1, 3);
        checkOutput("coll_d32", bus.o_rdata, 32'h0000_ABCD);
        do_write(1, 7, 32'hC0DE);
        applyStimulus(1, 1, 6, 32'h1234, 1, 7);
        checkOutput("coll_d16_other", bus.o_rdata, 32'hFFFF_C0DE);
        do_read("d16_read6", 1, 6, 32'h0000_1234);
        applyStimulus(1, 1, 7, 32'h7777, 1, 7);
        checkOutput("coll_d16_same", bus.o_rdata, 32'h0000_7777);

        exp_beats = '{32'h11, 32'h22, 32'h8001_0007, 32'h7777_1234};
        start_drain(4);
        drain_consume(4, 0);
        check_drain_end();
        start_drain(4);
        drain_consume(4, 1);
        check_drain_end();

        start_drain(4);
        @(negedge clk);
        bus.i_write = 1; bus.i_psum_mode = 0; bus.i_waddr = 6'd1; bus.i_wdata = 32'hDEAD;
        bus.i_drain_start = 1; bus.i_drain_size = 6'd2;
        @(posedge clk);
        #1;
        bus.i_write = 0; bus.i_drain_start = 0;
        checkOutput("err_set", 32'(bus.o_err), 32'd1);
        drain_consume(4, 0);
        check_drain_end();
        checkOutput("err_sticky", 32'(bus.o_err), 32'd1);
        do_read("mem_kept", 0, 1, 32'h22);
        @(negedge clk);
        bus.i_clear = 1;
        @(posedge clk);
        #1;
        bus.i_clear = 0;
        checkOutput("err_cleared", 32'(bus.o_err), 32'd0);

        exp_beats = '{32'h11, 32'h22};
        start_drain(5);
        drain_consume(2, 0);
        @(negedge clk);
        bus.i_Psum_ack = 0;
        bus.i_clear = 1;
        @(posedge clk);
        #1;
        bus.i_clear = 0;
        checkOutput("clear_rdy", 32'(bus.o_Psum_rdy), 32'd0);
        checkOutput("clear_done", 32'(bus.o_drain_done), 32'd0);
        checkOutput("clear_busy", 32'(bus.o_busy), 32'd0);

        @(negedge clk);
        bus.i_clear = 1; bus.i_drain_start = 1; bus.i_drain_size = 6'd4;
        @(posedge clk);
        #1;
        bus.i_clear = 0; bus.i_drain_start = 0;
        checkOutput("clear_prio", 32'(bus.o_busy), 32'd0);

        start_drain(4);
        @(negedge clk);
        bus.i_read = 1; bus.i_raddr = 6'd0;
        @(posedge clk);
        #1;
        bus.i_read = 0;
        checkOutput("err_mid", 32'(bus.o_err), 32'd1);
        #2;
        rst_n = 0;
        #1;
        checkOutput("rst_rdy", 32'(bus.o_Psum_rdy), 32'd0);
        checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("rst_err", 32'(bus.o_err), 32'd0);
        checkOutput("rst_pdata", bus.o_Psum_data, 32'd0);
        checkOutput("rst_rdata", bus.o_rdata, 32'd0);
        checkOutput("rst_rvalid", 32'(bus.o_rvalid), 32'd0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(posedge clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/psum_pad.md
Name: psum_pad

Overview:
- Partial-sum scratchpad directly downstream of the PE datapath controller.
- Consumes the controller's psum read/write control (address plus read/write strobes) and the psum-mode setting.
- Stores accumulated psums and returns read data to the shift/sum stage; supports 16-bit (D16) and 32-bit (D32) psum packing.
- After a tile completes, drains its contents to the PE output network over a rdy/ack stream.

Parameters:
- DEPTH, 32, number of 32-bit storage entries.
- ADDRWD, $clog2(DEPTH)+1, psum address width (one extra bit for D16 half-word addressing).
- DW, 32, entry and drain data width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous abort: FSM to IDLE, memory untouched.
- i_psum_mode  in  1  0=D32, 1=D16.
- i_read  in  1  psum read strobe.
- i_raddr  in  ADDRWD  psum read address.
- i_write  in  1  psum write strobe.
- i_waddr  in  ADDRWD  psum write address.
- i_wdata  in  DW  write data (D16 uses [15:0]).
- o_rdata  out  DW  read data, registered.
- o_rvalid  out  1  o_rdata valid this cycle.
- i_drain_start  in  1  begin drain (pulse).
- i_drain_size  in  $clog2(DEPTH)+1  number of entries to drain, 1..DEPTH.
- o_Psum_rdy  out  1  drain data valid.
- i_Psum_ack  in  1  drain consumer accept.
- o_Psum_data  out  DW  drain data.
- o_busy  out  1  drain in progress.
- o_drain_done  out  1  one-cycle pulse after the last drain beat.
- o_err  out  1  sticky: PE access or start attempted while busy.

Behaviour:
- Reset: all outputs 0; FSM = IDLE. Memory contents are undefined after reset; software-visible psums are always written before they are read.
- Addressing in D32: entry = addr[ADDRWD-2:0]; full-word access; addr[ADDRWD-1] is ignored.
- Addressing in D16: entry = addr[ADDRWD-1:1]; half = addr[0] (0 = [15:0], 1 = [31:16]).
  - A write updates only the selected half, with data from i_wdata[15:0].
  - A read returns the selected half sign-extended to DW.
- Read latency is 1 cycle: o_rdata and o_rvalid are registered from an i_read in the previous cycle. o_rvalid = 0 when no read occurred; o_rdata holds its last value.
- Read/write collision (same entry and same half, both strobes in one cycle): the read returns i_wdata (write-forwarded, with the same D16 extension).
  - D16, same entry, different halves: the read returns the stored half; the write proceeds.
- FSM states IDLE, DRAIN.
- IDLE -> DRAIN on i_drain_start:
  - latch size N;
  - read pointer = 0;
  - load entry 0 into the output register;
  - o_Psum_rdy = 1 on the following cycle.
- In DRAIN, o_Psum_data is stable while o_Psum_rdy && !i_Psum_ack.
  - On each rdy&&ack with a beat remaining: the next entry is loaded the same cycle, so there are no bubbles and the next beat is presented the following cycle.
  - On the ack of beat N: o_Psum_rdy drops the next cycle; o_drain_done pulses one cycle; FSM -> IDLE.
- o_busy = (state == DRAIN).
- While busy:
  - i_read and i_write are ignored (no memory change, o_rvalid = 0) and set o_err;
  - i_drain_start is ignored and sets o_err.
- i_drain_size = 0 is treated as DEPTH. Values > DEPTH saturate to DEPTH.
- i_clear:
  - In any state: FSM -> IDLE next cycle; o_Psum_rdy = 0; no o_drain_done pulse; o_err cleared.
  - i_clear has priority over i_drain_start in the same cycle.
- A PE write and an i_drain_start in the same IDLE cycle: the write is committed first, and drain entry 0 reflects it.

Test Plan:
- D32, write entries 0..3 = 0x11,0x22,0x33,0x44 -> read addr 2 gives o_rdata = 0x33 with o_rvalid one cycle after i_read.
- D16, write addr 5 = 0x8001 and addr 4 = 0x0007 -> read addr 5 gives 0xFFFF8001, read addr 4 gives 0x00000007, and a drain of entry 2 yields 0x80010007.
- Collision: D32 write 0xABCD to addr 3 with a same-cycle read of addr 3 -> o_rdata = 0xABCD. D16 write addr 6 with read addr 7 (same entry, other half) -> old half returned.
- Drain N=4 with ack held high -> 4 consecutive beats of entries 0..3, o_drain_done pulse in the cycle after the 4th ack, o_busy low afterwards. Repeat with ack toggling every other cycle -> data held stable while unacked, same 4 values in order.
- During drain, assert i_write and i_drain_start -> memory unchanged (checked by a later read), o_err = 1 and sticky until i_clear.
- i_clear asserted after 2 of 5 beats -> o_Psum_rdy = 0 next cycle, no o_drain_done, FSM IDLE. Assert i_rst_n low mid-drain -> all outputs 0 immediately.
